// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry, pointer type and Gray-code
// conversions used by the write/read controllers and the memory.
package fifo_pkg;

  localparam int PTR_WIDTH = 8;
  localparam int DEPTH     = 1 << PTR_WIDTH;

  // Pointers carry one extra wrap bit above the memory address.
  typedef logic [PTR_WIDTH:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_WIDTH] = g[PTR_WIDTH];
    for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded bus crossing into the local clock domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;

  // NOTE: non-blocking assignments keep the two stages a true shift; with
  // blocking ones the input would race straight through both flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      o_q    <= '0;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and status controller: write address, Gray pointer export,
// synchronised read pointer, full/almost_full/level and overflow reporting.
module wptr_full_ctrl #(
  parameter int PTR_WIDTH      = fifo_pkg::PTR_WIDTH,
  parameter int DEPTH          = fifo_pkg::DEPTH,
  parameter int ALMOST_FULL_TH = 224
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic               w_en,
  input  logic [PTR_WIDTH:0] g_rptr_async,
  input  logic               clr_err,
  output logic [PTR_WIDTH:0] b_wptr,
  output logic [PTR_WIDTH:0] g_wptr,
  output logic               full,
  output logic               almost_full,
  output logic [PTR_WIDTH:0] w_level,
  output logic               overflow,
  output logic               overflow_sticky
);

  import fifo_pkg::ptr_t;
  import fifo_pkg::bin2gray;
  import fifo_pkg::gray2bin;

  localparam int AF_TH_CLAMP = (ALMOST_FULL_TH > DEPTH) ? DEPTH : ALMOST_FULL_TH;
  localparam logic [PTR_WIDTH:0] AF_TH = AF_TH_CLAMP[PTR_WIDTH:0];

  logic [PTR_WIDTH:0] w_g_rptr_s;
  logic [PTR_WIDTH:0] w_rbin;
  logic [PTR_WIDTH:0] w_b_wptr_next;
  logic [PTR_WIDTH:0] w_g_wptr_next;
  logic [PTR_WIDTH:0] w_level_next;
  logic [PTR_WIDTH:0] w_g_rptr_full;
  ptr_t               w_rbin_pkg;
  ptr_t               w_g_next_pkg;
  logic               w_accept;
  logic               w_full_next;
  logic               w_ovf_next;

  sync_2ff #(
    .WIDTH(PTR_WIDTH + 1)
  ) u_sync_rptr (
    .clk  (wclk),
    .rst_n(wrst_n),
    .i_d  (g_rptr_async),
    .o_q  (w_g_rptr_s)
  );

  // Package helpers are sized for the package width; narrower pointers are
  // zero-extended, which leaves both conversions exact.
  assign w_rbin_pkg = gray2bin(ptr_t'(w_g_rptr_s));
  assign w_rbin     = w_rbin_pkg[PTR_WIDTH:0];

  assign w_accept      = w_en && !full;
  assign w_ovf_next    = w_en && full;
  assign w_b_wptr_next = b_wptr + {{PTR_WIDTH{1'b0}}, w_accept};
  assign w_g_next_pkg  = bin2gray(ptr_t'(w_b_wptr_next));
  assign w_g_wptr_next = w_g_next_pkg[PTR_WIDTH:0];
  assign w_level_next  = w_b_wptr_next - w_rbin;

  // Full when the write pointer is exactly one lap ahead: in Gray code that is
  // the read pointer with its two top bits inverted.
  assign w_g_rptr_full = {~w_g_rptr_s[PTR_WIDTH -: 2], w_g_rptr_s[PTR_WIDTH-2:0]};
  assign w_full_next   = (w_g_wptr_next == w_g_rptr_full);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      b_wptr          <= '0;
      g_wptr          <= '0;
      full            <= 1'b0;
      almost_full     <= 1'b0;
      w_level         <= '0;
      overflow        <= 1'b0;
      overflow_sticky <= 1'b0;
    end else begin
      b_wptr          <= w_b_wptr_next;
      g_wptr          <= w_g_wptr_next;
      full            <= w_full_next;
      almost_full     <= (w_level_next >= AF_TH);
      w_level         <= w_level_next;
      overflow        <= w_ovf_next;
      overflow_sticky <= w_ovf_next | (overflow_sticky & ~clr_err);
    end
  end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl: directed scenarios plus random traffic,
// compared every cycle against a count-based model of the FIFO occupancy.
module tb_wptr_full_ctrl;

  localparam int PW    = 8;
  localparam int DEPTH = 256;
  localparam int TH    = 224;

  logic          wclk;
  logic          wrst_n;
  logic          w_en;
  logic          clr_err;
  logic [PW:0]   r_bin;
  logic [PW:0]   g_rptr_async;
  logic [PW:0]   b_wptr;
  logic [PW:0]   g_wptr;
  logic          full;
  logic          almost_full;
  logic [PW:0]   w_level;
  logic          overflow;
  logic          overflow_sticky;

  int checks = 0;
  int errors = 0;

  assign g_rptr_async = r_bin ^ (r_bin >> 1);

  wptr_full_ctrl #(
    .PTR_WIDTH     (PW),
    .DEPTH         (DEPTH),
    .ALMOST_FULL_TH(TH)
  ) dut (
    .wclk           (wclk),
    .wrst_n         (wrst_n),
    .w_en           (w_en),
    .g_rptr_async   (g_rptr_async),
    .clr_err        (clr_err),
    .b_wptr         (b_wptr),
    .g_wptr         (g_wptr),
    .full           (full),
    .almost_full    (almost_full),
    .w_level        (w_level),
    .overflow       (overflow),
    .overflow_sticky(overflow_sticky)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counts of writes accepted and reads released (mod 2*DEPTH); the read
  // count is the value driven two edges earlier, mirroring the crossing delay.
  logic [PW:0] m_w, m_lvl, m_h1, m_h2;
  logic        m_full, m_af, m_ovf, m_sticky;

  initial begin
    m_w = '0; m_lvl = '0; m_h1 = '0; m_h2 = '0;
    m_full = 0; m_af = 0; m_ovf = 0; m_sticky = 0;
    forever begin
      @(posedge wclk or negedge wrst_n);
      if (!wrst_n) begin
        m_w = '0; m_lvl = '0; m_h1 = '0; m_h2 = '0;
        m_full = 0; m_af = 0; m_ovf = 0; m_sticky = 0;
      end else begin
        m_ovf    = w_en && m_full;
        m_sticky = m_ovf || (m_sticky && !clr_err);
        if (w_en && !m_full) m_w = m_w + 1'b1;
        m_lvl  = m_w - m_h2;
        m_full = (m_lvl == 9'(DEPTH));
        m_af   = (int'(m_lvl) >= TH);
        m_h2   = m_h1;
        m_h1   = r_bin;
      end
    end
  end

  logic [PW:0] prev_g;
  bit          prev_valid = 0;

  initial begin
    forever begin
      @(negedge wclk);
      check("b_wptr",          b_wptr,          m_w);
      check("g_wptr",          g_wptr,          m_w ^ (m_w >> 1));
      check("w_level",         w_level,         m_lvl);
      check("full",            full,            m_full);
      check("almost_full",     almost_full,     m_af);
      check("overflow",        overflow,        m_ovf);
      check("overflow_sticky", overflow_sticky, m_sticky);
      if (wrst_n && prev_valid)
        check("g_wptr_one_bit", ($countones(g_wptr ^ prev_g) <= 1), 1);
      prev_g     = g_wptr;
      prev_valid = wrst_n;
    end
  end

  task automatic do_reset();
    @(negedge wclk);
    w_en = 0; clr_err = 0; r_bin = '0;
    wrst_n = 0;
    @(negedge wclk);
    #2 wrst_n = 1;
  endtask

  int wp, rp;

  initial begin
    wrst_n = 0; w_en = 0; clr_err = 0; r_bin = '0;
    repeat (3) @(negedge wclk);
    #1;
    check("rst_b_wptr", b_wptr, 0);
    check("rst_full",   full,   0);
    wrst_n = 1;

    // Asynchronous reset mid-stream.
    w_en = 1;
    repeat (37) @(negedge wclk);
    check("pre_rst_b_wptr", b_wptr, 37);
    w_en = 0;
    #3 wrst_n = 0;
    #1;
    check("async_rst_b_wptr",  b_wptr,          0);
    check("async_rst_g_wptr",  g_wptr,          0);
    check("async_rst_level",   w_level,         0);
    check("async_rst_flags",   {full, almost_full, overflow, overflow_sticky}, 0);
    @(negedge wclk);
    #2 wrst_n = 1;
    w_en = 1;
    @(negedge wclk);
    w_en = 0;
    check("first_b_wptr", b_wptr, 1);
    check("first_g_wptr", g_wptr, 1);

    // Fill from empty.
    do_reset();
    w_en = 1;
    for (int i = 1; i <= 256; i++) begin
      @(negedge wclk);
      if (i == 223) check("af_at_223",  almost_full, 0);
      if (i == 224) check("af_at_224",  almost_full, 1);
      if (i == 255) check("full_at_255", full, 0);
      if (i == 256) check("full_at_256", full, 1);
    end
    check("fill_b_wptr", b_wptr,  9'h100);
    check("fill_g_wptr", g_wptr,  9'h180);
    check("fill_level",  w_level, 256);

    // Overflow while full, then sticky clear priority.
    for (int i = 0; i < 2; i++) begin
      @(negedge wclk);
      check("ovf_pulse",  overflow, 1);
      check("ovf_b_wptr", b_wptr,   9'h100);
    end
    check("ovf_sticky", overflow_sticky, 1);
    clr_err = 1;
    @(negedge wclk);
    check("clr_vs_ovf_sticky", overflow_sticky, 1);
    w_en = 0;
    @(negedge wclk);
    check("clr_alone_sticky", overflow_sticky, 0);
    clr_err = 0;

    // Read release latency.
    r_bin = 9'd1;
    @(negedge wclk);
    check("rel_e1_full", full, 1);
    check("rel_e1_af",   almost_full, 1);
    @(negedge wclk);
    check("rel_e2_full", full, 1);
    @(negedge wclk);
    check("rel_e3_full",  full,    0);
    check("rel_e3_level", w_level, 255);

    // Simultaneous write and read release at level 224.
    for (int r = 2; r <= 32; r++) begin
      r_bin = 9'(r);
      @(negedge wclk);
    end
    repeat (2) @(negedge wclk);
    check("sim_pre_level", w_level, 224);
    r_bin = 9'd33;
    repeat (2) @(negedge wclk);
    w_en = 1;
    @(negedge wclk);
    w_en = 0;
    check("sim_level",  w_level,     224);
    check("sim_af",     almost_full, 1);
    check("sim_b_wptr", b_wptr,      9'h101);
    @(negedge wclk);
    check("sim_level_hold", w_level, 224);

    // Pointer wrap with the reader trailing by ten entries.
    do_reset();
    w_en = 1;
    repeat (10) @(negedge wclk);
    check("wrap_start_level", w_level, 10);
    for (int i = 0; i < 600; i++) begin
      r_bin = m_w - 9'd7;
      @(negedge wclk);
      if (i >= 3) begin
        check("wrap_level", w_level, 10);
        check("wrap_full",  full,    0);
      end
    end
    w_en = 0;

    // Random traffic: producer-heavy, then consumer-heavy.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      wp = (i < 1500) ? 7 : 3;
      rp = (i < 1500) ? 4 : 6;
      @(negedge wclk);
      w_en    = ($urandom % 10) < wp;
      clr_err = ($urandom % 16) == 0;
      if (r_bin != m_w && ($urandom % 10) < rp) r_bin = r_bin + 1'b1;
    end
    w_en = 0; clr_err = 0;
    @(negedge wclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
